reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dispatches allocate at tail, completions land out of order,
// the head retires in order, and a mispredicted branch at retirement flushes everything.

module reorder_buffer_entry #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             disp_we,
  input  logic [4:0]       disp_rd_addr,
  input  logic             disp_rf_w_en,
  input  logic             disp_mem_w_en,
  input  logic             cmpl_sel,
  input  logic [WIDTH-1:0] cmpl_data,
  input  logic             cmpl_mispredict,
  input  logic [WIDTH-1:0] cmpl_br_tar,
  input  logic             retire,
  output logic             valid,
  output logic             done,
  output logic [4:0]       rd_addr,
  output logic             rf_w_en,
  output logic             mem_w_en,
  output logic             mispredict,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] br_tar
);

  // A dispatch only targets an invalid slot and a retire only a done one, so the
  // three update sources never collide on the same entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid      <= 1'b0;
      done       <= 1'b0;
      rd_addr    <= '0;
      rf_w_en    <= 1'b0;
      mem_w_en   <= 1'b0;
      mispredict <= 1'b0;
      data       <= '0;
      br_tar     <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (disp_we) begin
      valid      <= 1'b1;
      done       <= 1'b0;
      rd_addr    <= disp_rd_addr;
      rf_w_en    <= disp_rf_w_en;
      mem_w_en   <= disp_mem_w_en;
      mispredict <= 1'b0;
      data       <= '0;
      br_tar     <= '0;
    end else if (retire) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (cmpl_sel && valid && !done) begin
      done       <= 1'b1;
      data       <= cmpl_data;
      mispredict <= cmpl_mispredict;
      br_tar     <= cmpl_br_tar;
    end
  end

endmodule

module reorder_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [4:0]       disp_rd_addr,
  input  logic             disp_rf_w_en,
  input  logic             disp_mem_w_en,
  output logic [TAG_W-1:0] disp_tag,
  input  logic             cmpl_valid,
  input  logic [TAG_W-1:0] cmpl_tag,
  input  logic [WIDTH-1:0] cmpl_data,
  input  logic             cmpl_mispredict,
  input  logic [WIDTH-1:0] cmpl_br_tar,
  output logic             commit_valid,
  input  logic             commit_ready,
  output logic [4:0]       commit_rd_addr,
  output logic             commit_rf_w_en,
  output logic             commit_mem_w_en,
  output logic [WIDTH-1:0] commit_data,
  output logic             flush,
  output logic [WIDTH-1:0] flush_pc,
  output logic [TAG_W:0]   count,
  input  logic [4:0]       src1_addr,
  input  logic [4:0]       src2_addr,
  output logic             src1_hit,
  output logic             src1_done,
  output logic [TAG_W-1:0] src1_tag,
  output logic [WIDTH-1:0] src1_data,
  output logic             src2_hit,
  output logic             src2_done,
  output logic [TAG_W-1:0] src2_tag,
  output logic [WIDTH-1:0] src2_data
);

  typedef struct packed {
    logic             hit;
    logic             done;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
  } lookup_t;

  logic [DEPTH-1:0]            valid, done, rf_w_en, mem_w_en, mispredict;
  logic [DEPTH-1:0][4:0]       rd_addr;
  logic [DEPTH-1:0][WIDTH-1:0] data, br_tar;

  logic [TAG_W-1:0] head, tail, idx;
  logic [TAG_W:0]   cnt;
  logic             disp_fire, retire;
  logic [1:0][4:0]  src_addr;
  lookup_t [1:0]    lk;

  assign commit_valid    = valid[head] & done[head];
  assign commit_rd_addr  = rd_addr[head];
  assign commit_rf_w_en  = rf_w_en[head];
  assign commit_mem_w_en = mem_w_en[head];
  assign commit_data     = data[head];
  assign retire          = commit_valid & commit_ready;
  assign flush           = retire & mispredict[head];
  assign flush_pc        = flush ? br_tar[head] : '0;

  assign disp_ready = (cnt < (TAG_W+1)'(DEPTH)) && !flush;
  assign disp_fire  = disp_valid & disp_ready;
  assign disp_tag   = tail;
  assign count      = cnt;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    reorder_buffer_entry #(.WIDTH(WIDTH)) u_entry (
      .clk             (clk),
      .reset           (reset),
      .flush           (flush),
      .disp_we         (disp_fire && (tail == TAG_W'(i))),
      .disp_rd_addr    (disp_rd_addr),
      .disp_rf_w_en    (disp_rf_w_en),
      .disp_mem_w_en   (disp_mem_w_en),
      .cmpl_sel        (cmpl_valid && (cmpl_tag == TAG_W'(i))),
      .cmpl_data       (cmpl_data),
      .cmpl_mispredict (cmpl_mispredict),
      .cmpl_br_tar     (cmpl_br_tar),
      .retire          (retire && (head == TAG_W'(i))),
      .valid           (valid[i]),
      .done            (done[i]),
      .rd_addr         (rd_addr[i]),
      .rf_w_en         (rf_w_en[i]),
      .mem_w_en        (mem_w_en[i]),
      .mispredict      (mispredict[i]),
      .data            (data[i]),
      .br_tar          (br_tar[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (disp_fire) tail <= tail + 1'b1;
      if (retire)    head <= head + 1'b1;
      unique case ({disp_fire, retire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Walk oldest to youngest so the last match wins: the youngest producer of the register.
  assign src_addr = {src2_addr, src1_addr};

  always_comb begin
    lk  = '0;
    idx = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + TAG_W'(i);
        if (valid[idx] && rf_w_en[idx] && (src_addr[s] != 5'd0) &&
            (rd_addr[idx] == src_addr[s])) begin
          lk[s].hit  = 1'b1;
          lk[s].done = done[idx];
          lk[s].tag  = idx;
          lk[s].data = data[idx];
        end
      end
    end
  end

  assign src1_hit  = lk[0].hit;
  assign src1_done = lk[0].done;
  assign src1_tag  = lk[0].tag;
  assign src1_data = lk[0].data;
  assign src2_hit  = lk[1].hit;
  assign src2_done = lk[1].done;
  assign src2_tag  = lk[1].tag;
  assign src2_data = lk[1].data;

endmodule
